// File: rtl/seq_circuit_pkg.sv
// seq_circuit_pkg -- shared state encoding for the seq_circuit Mealy machine.
// The state is the 2-bit register {A,B}; the encodings below are fixed
// because A and B are brought straight out as ports.
package seq_circuit_pkg;

  typedef enum logic [1:0] {
    S00 = 2'b00,
    S01 = 2'b01,
    S11 = 2'b11,
    S10 = 2'b10
  } state_t;

  localparam state_t RESET_STATE = S00;

endpackage : seq_circuit_pkg

// File: rtl/seq_circuit_nsl.sv
// seq_circuit_nsl -- next-state and output logic for seq_circuit.
// Purely combinational:
//   A+ = (A & x) | (B & x)
//   B+ = ~A & x
//   y  = (A | B) & ~x
// X/Z on x propagates unmasked into next_state and y_comb.
module seq_circuit_nsl
  import seq_circuit_pkg::*;
(
  input  state_t state,
  input  logic   x,
  output state_t next_state,
  output logic   y_comb
);

  logic a_cur;
  logic b_cur;

  assign a_cur = state[1];
  assign b_cur = state[0];

  // Next-state equations and the Mealy output.
  always_comb begin
    // NOTE: every output of an always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    next_state = RESET_STATE;
    y_comb     = 1'b0;
    next_state = state_t'({(a_cur & x) | (b_cur & x), ~a_cur & x});
    y_comb     = (a_cur | b_cur) & ~x;
  end

endmodule : seq_circuit_nsl

// File: rtl/seq_circuit.sv
// seq_circuit -- 2-bit Mealy sequence machine with state outputs A (MSB)
// and B (LSB) and output y.
// Configuration macro SEQ_CIRCUIT_REG_Y_EN:
//   undefined (default) -> y is combinational, zero latency from x.
//   defined             -> y is registered, one cycle of latency, async
//                          reset to 0.
// State behaviour is identical in both builds. Reset deassertion is assumed
// to be synchronized outside this block.
module seq_circuit
  import seq_circuit_pkg::*;
(
  input  logic x,
  input  logic clk,
  input  logic reset,
  output logic A,
  output logic B,
  output logic y
);

  state_t state_q;
  state_t state_d;
  logic   y_comb;

  seq_circuit_nsl u_nsl (
    .state      (state_q),
    .x          (x),
    .next_state (state_d),
    .y_comb     (y_comb)
  );

  // State register; reset forces S00 immediately, without a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state is written with non-blocking assignments so
    // every flop samples its inputs from before the edge.
    if (!reset) state_q <= RESET_STATE;
    else        state_q <= state_d;
  end

  // A and B come straight from the flops, so they cannot glitch.
  assign A = state_q[1];
  assign B = state_q[0];

`ifdef SEQ_CIRCUIT_REG_Y_EN
  logic y_q;

  // Registered Mealy output: one cycle behind the combinational value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) y_q <= 1'b0;
    else        y_q <= y_comb;
  end

  assign y = y_q;
`else
  assign y = y_comb;
`endif

endmodule : seq_circuit

// File: tb/tb_seq_circuit.sv
// tb_seq_circuit -- directed self-checking bench for seq_circuit.
// Works in both builds: with SEQ_CIRCUIT_REG_Y_EN defined, y is checked
// one clock after the state/x that produced it instead of immediately.
`timescale 1ns/1ps
module tb_seq_circuit;

  logic x;
  logic clk;
  logic reset;
  logic A;
  logic B;
  logic y;

  int n_checks = 0;
  int n_errors = 0;

  seq_circuit dut (
    .x     (x),
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_y(input string tag, input logic exp);
    check(tag, {1'b0, y}, {1'b0, exp});
  endtask

  // Apply x (called just after a rising edge). exp_y is the Mealy value for
  // the current state and this x; exp_ab is the state after the next edge.
  task automatic step(input string tag, input logic xv, input logic exp_y,
                      input logic [1:0] exp_ab);
    x = xv;
    #1;
`ifndef SEQ_CIRCUIT_REG_Y_EN
    check_y({tag, ".y"}, exp_y);
`endif
    @(posedge clk);
    #1;
    check({tag, ".ab"}, {A, B}, exp_ab);
`ifdef SEQ_CIRCUIT_REG_Y_EN
    check_y({tag, ".y"}, exp_y);
`endif
  endtask

  // Assert reset with x=0, check it takes effect at once, release it
  // between edges, then confirm S00 holds across one clock.
  task automatic apply_reset(input string tag);
    x     = 1'b0;
    reset = 1'b0;
    #1;
    check({tag, ".rst_ab"}, {A, B}, 2'b00);
    check_y({tag, ".rst_y"}, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check({tag, ".rel_ab"}, {A, B}, 2'b00);
    check_y({tag, ".rel_y"}, 1'b0);
  endtask

  // Exhaustive table, state index 0..3 = S00, S01, S11, S10.
  logic [1:0] path   [3] = '{2'b01, 2'b11, 2'b10};
  logic [1:0] nxt_x1 [4] = '{2'b01, 2'b11, 2'b10, 2'b10};
  logic       y_x0   [4] = '{1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    x     = 1'b0;
    reset = 1'b0;
    #2;
    check("por_ab", {A, B}, 2'b00);
    check_y("por_y", 1'b0);
    @(posedge clk);
    #1;

    // Reset, then S00 must hold for two clocks with x=0.
    apply_reset("r1");
    step("hold0", 1'b0, 1'b0, 2'b00);
    step("hold1", 1'b0, 1'b0, 2'b00);

    // Ascending sequence saturating in S10.
    step("asc0", 1'b1, 1'b0, 2'b01);
    step("asc1", 1'b1, 1'b0, 2'b11);
    step("asc2", 1'b1, 1'b0, 2'b10);
    step("asc3", 1'b1, 1'b0, 2'b10);

    // Mealy output from S10, then back in S00.
    step("mealy0", 1'b0, 1'b1, 2'b00);
    step("mealy1", 1'b0, 1'b0, 2'b00);

    // Alternating pairs from S00.
    apply_reset("r2");
    step("alt0", 1'b0, 1'b0, 2'b00);
    step("alt1", 1'b0, 1'b0, 2'b00);
    step("alt2", 1'b1, 1'b0, 2'b01);
    step("alt3", 1'b1, 1'b0, 2'b11);
    step("alt4", 1'b0, 1'b1, 2'b00);
    step("alt5", 1'b0, 1'b0, 2'b00);
    step("alt6", 1'b1, 1'b0, 2'b01);
    step("alt7", 1'b1, 1'b0, 2'b11);

    // Async reset in S11 with x=0 (y_comb high), between clock edges.
    x = 1'b0;
    #1;
`ifndef SEQ_CIRCUIT_REG_Y_EN
    check_y("async_pre_y", 1'b1);
`endif
    #2;
    reset = 1'b0;
    #1;
    check("async_ab", {A, B}, 2'b00);
    check_y("async_y", 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("async_rel_ab", {A, B}, 2'b00);

    // Exhaustive: every state with x=0 and x=1.
    for (int s = 0; s < 4; s++) begin
      for (int xv = 0; xv < 2; xv++) begin
        apply_reset($sformatf("ex%0d%0d", s, xv));
        for (int k = 0; k < s; k++)
          step($sformatf("ex%0d%0d_path%0d", s, xv, k), 1'b1, 1'b0, path[k]);
        if (xv == 0)
          step($sformatf("ex%0d_x0", s), 1'b0, y_x0[s], 2'b00);
        else
          step($sformatf("ex%0d_x1", s), 1'b1, 1'b0, nxt_x1[s]);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_seq_circuit
